// File: rtl/ibex_pkg.sv
// ibex_pkg
// Shared types for the multi-entry writeback buffer.
//   wb_instr_type_e : class of an issued instruction (load / store / other)
//   wb_entry_t      : one buffered instruction, payload captured at push
//   fwd_src_t       : per-entry view consumed by the forwarding lookup
package ibex_pkg;

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'd0,
        WB_INSTR_STORE = 2'd1,
        WB_INSTR_OTHER = 2'd2
    } wb_instr_type_e;

    // FP payload is stored at the widest supported FP width; narrower
    // configurations use the low bits only.
    localparam int WbFpDataMax = 64;

    typedef struct packed {
        wb_instr_type_e         instr_type;
        logic [31:0]            pc;
        logic [4:0]             waddr;
        logic [31:0]            wdata;
        logic [WbFpDataMax-1:0] fp_wdata;
        logic                   rf_we;
        logic                   fp_wen;
        logic                   fp_load;
        logic                   compressed;
        logic                   perf_count;
    } wb_entry_t;

    // active  : entry is valid and will write the integer RF
    // is_load : that write comes from the LSU (data not yet available)
    typedef struct packed {
        logic        active;
        logic        is_load;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } fwd_src_t;

endpackage

// File: rtl/ibex_wb_fwd_lookup.sv
// ibex_wb_fwd_lookup
// Age-ordered priority match of one ID read port against the buffered
// integer writers.
//   srcs      in  Depth x fwd_src_t, index 0 = oldest, Depth-1 = youngest
//   raddr     in  5     read address of this port
//   fwd_valid out 1     youngest matching writer is a completed ALU result
//   fwd_data  out 32    that result (0 when fwd_valid is low)
//   hazard    out 1     youngest matching writer is a pending load
module ibex_wb_fwd_lookup
    import ibex_pkg::*;
#(
    parameter int Depth = 2
) (
    input  fwd_src_t [Depth-1:0] srcs,
    input  logic     [4:0]       raddr,
    output logic                 fwd_valid,
    output logic     [31:0]      fwd_data,
    output logic                 hazard
);

    logic        found;
    logic        found_load;
    logic [31:0] found_data;

    // Walking oldest to youngest and letting later hits overwrite earlier
    // ones is equivalent to taking the first hit of a youngest-first scan.
    // x0 is hardwired to zero and never matches.
    always_comb begin
        found      = 1'b0;
        found_load = 1'b0;
        found_data = '0;
        for (int k = 0; k < Depth; k++) begin
            if (srcs[k].active && (srcs[k].waddr == raddr) && (raddr != 5'd0)) begin
                found      = 1'b1;
                found_load = srcs[k].is_load;
                found_data = srcs[k].wdata;
            end
        end
    end

    assign fwd_valid = found & ~found_load;
    assign hazard    = found & found_load;
    assign fwd_data  = fwd_valid ? found_data : '0;

endmodule

// File: rtl/ibex_wb_buffer.sv
// ibex_wb_buffer
// In-order writeback buffer between ID/EX and the integer and FP register
// files. Holds up to Depth issued instructions so ID/EX keeps issuing while
// loads/stores wait for the LSU; retires strictly from the head.
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   en_wb_i ... fp_load_i               instruction offered by ID/EX (push)
//   lsu_resp_*, rf_we_lsu_i, rf_wdata_lsu_i   LSU response for the head entry
//   rf_raddr_i                          ID read addresses, ports A/B
//   ready_wb_o                          offer accepted this cycle
//   outstanding_load/store_wb_o         any buffered load / store
//   pc_wb_o, instr_done_wb_o, perf_*    head retirement information
//   rf_waddr/we/wdata_wb_o              integer RF write port
//   fp_rf_wen/wdata_wb_o                FP RF write port
//   rf_fwd_valid/data_o, rf_hazard_o    per-port forwarding and load-use hazard
//   fp_rf_pending_o                     FP registers with a pending write
module ibex_wb_buffer
    import ibex_pkg::*;
#(
    parameter int Depth     = 2,
    parameter bit FpEnable  = 1'b1,
    parameter int FPU_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  en_wb_i,
    input  wb_instr_type_e        instr_type_wb_i,
    input  logic [31:0]           pc_id_i,
    input  logic                  instr_is_compressed_id_i,
    input  logic                  instr_perf_count_id_i,
    input  logic [4:0]            rf_waddr_id_i,
    input  logic [31:0]           rf_wdata_id_i,
    input  logic                  rf_we_id_i,
    input  logic                  fp_rf_wen_id_i,
    input  logic [FPU_WIDTH-1:0]  fp_rf_wdata_id_i,
    input  logic                  fp_load_i,

    input  logic                  lsu_resp_valid_i,
    input  logic                  lsu_resp_err_i,
    input  logic                  rf_we_lsu_i,
    input  logic [31:0]           rf_wdata_lsu_i,

    input  logic [1:0][4:0]       rf_raddr_i,

    output logic                  ready_wb_o,
    output logic                  outstanding_load_wb_o,
    output logic                  outstanding_store_wb_o,
    output logic [31:0]           pc_wb_o,
    output logic                  instr_done_wb_o,
    output logic                  perf_instr_ret_wb_o,
    output logic                  perf_instr_ret_compressed_wb_o,
    output logic [4:0]            rf_waddr_wb_o,
    output logic                  rf_we_wb_o,
    output logic [31:0]           rf_wdata_wb_o,
    output logic                  fp_rf_wen_wb_o,
    output logic [FPU_WIDTH-1:0]  fp_rf_wdata_wb_o,
    output logic [1:0]            rf_fwd_valid_o,
    output logic [1:0][31:0]      rf_fwd_data_o,
    output logic [1:0]            rf_hazard_o,
    output logic [31:0]           fp_rf_pending_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [PtrW-1:0]      head_ptr;
    logic [PtrW-1:0]      tail_ptr;
    logic [CntW-1:0]      count;
    wb_entry_t            entries [Depth];

    wb_entry_t            head;
    wb_entry_t            new_entry;
    logic                 head_valid;
    logic                 head_is_other;
    logic                 head_is_load;
    logic                 head_done;
    logic                 push;
    logic                 pop;

    logic                 int_we_alu;
    logic                 int_we_lsu;
    logic [63:0]          fp_lsu_boxed;
    logic                 unused_fp_bits;

    fwd_src_t [Depth-1:0] fwd_srcs;
    logic                 any_load;
    logic                 any_store;
    logic [31:0]          fp_pending;
    int                   slot;
    wb_entry_t            scan_entry;

    // Pointers wrap at Depth-1 so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign head          = entries[head_ptr];
    assign head_valid    = (count != '0);
    assign head_is_other = (head.instr_type == WB_INSTR_OTHER);
    assign head_is_load  = (head.instr_type == WB_INSTR_LOAD);

    // A retiring head frees its slot in the same cycle, so a full buffer
    // can still accept a push alongside the pop.
    assign head_done  = head_valid & (head_is_other | lsu_resp_valid_i);
    assign ready_wb_o = (count < DepthCnt) | head_done;
    assign push       = en_wb_i & ready_wb_o;
    assign pop        = head_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= ptr_inc(tail_ptr);
            end
            if (pop) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        new_entry            = '0;
        new_entry.instr_type = instr_type_wb_i;
        new_entry.pc         = pc_id_i;
        new_entry.waddr      = rf_waddr_id_i;
        new_entry.wdata      = rf_wdata_id_i;
        new_entry.fp_wdata   = WbFpDataMax'(fp_rf_wdata_id_i);
        new_entry.rf_we      = rf_we_id_i;
        new_entry.fp_wen     = FpEnable & fp_rf_wen_id_i;
        new_entry.fp_load    = fp_load_i;
        new_entry.compressed = instr_is_compressed_id_i;
        new_entry.perf_count = instr_perf_count_id_i;
    end

    // Payload storage is deliberately not reset; validity lives in count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries[tail_ptr] <= new_entry;
        end
    end

    // Build an age-ordered view (0 = head/oldest) of the valid entries for
    // forwarding, outstanding flags and FP pending bits. Only registered
    // state is used, so an entry being pushed this cycle is invisible while
    // the entry being popped is still seen.
    always_comb begin
        fwd_srcs   = '0;
        any_load   = 1'b0;
        any_store  = 1'b0;
        fp_pending = '0;
        slot       = 0;
        scan_entry = '0;
        for (int k = 0; k < Depth; k++) begin
            slot = int'(head_ptr) + k;
            if (slot >= Depth) begin
                slot = slot - Depth;
            end
            scan_entry = entries[slot[PtrW-1:0]];
            if (k < int'(count)) begin
                if (scan_entry.instr_type == WB_INSTR_LOAD) begin
                    any_load = 1'b1;
                end
                if (scan_entry.instr_type == WB_INSTR_STORE) begin
                    any_store = 1'b1;
                end
                if (scan_entry.fp_wen ||
                    ((scan_entry.instr_type == WB_INSTR_LOAD) && scan_entry.fp_load)) begin
                    fp_pending[scan_entry.waddr] = 1'b1;
                end
                fwd_srcs[k].active  = scan_entry.rf_we ||
                                      ((scan_entry.instr_type == WB_INSTR_LOAD) && !scan_entry.fp_load);
                fwd_srcs[k].is_load = (scan_entry.instr_type == WB_INSTR_LOAD);
                fwd_srcs[k].waddr   = scan_entry.waddr;
                fwd_srcs[k].wdata   = scan_entry.wdata;
            end
        end
    end

    assign outstanding_load_wb_o  = any_load;
    assign outstanding_store_wb_o = any_store;
    assign fp_rf_pending_o        = FpEnable ? fp_pending : '0;

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        ibex_wb_fwd_lookup #(
            .Depth (Depth)
        ) u_fwd_lookup (
            .srcs      (fwd_srcs),
            .raddr     (rf_raddr_i[p]),
            .fwd_valid (rf_fwd_valid_o[p]),
            .fwd_data  (rf_fwd_data_o[p]),
            .hazard    (rf_hazard_o[p])
        );
    end

    // 32-bit FP load data is NaN-boxed when the FP RF is wider.
    assign fp_lsu_boxed   = {32'hFFFF_FFFF, rf_wdata_lsu_i};
    assign unused_fp_bits = ^{fp_lsu_boxed, head.fp_wdata};

    assign int_we_alu = head_valid & head_is_other & head.rf_we;
    assign int_we_lsu = head_valid & head_is_load & rf_we_lsu_i & ~head.fp_load;

    always_comb begin
        rf_we_wb_o       = int_we_alu | int_we_lsu;
        rf_wdata_wb_o    = '0;
        fp_rf_wen_wb_o   = 1'b0;
        fp_rf_wdata_wb_o = '0;
        if (int_we_alu) begin
            rf_wdata_wb_o = head.wdata;
        end else if (int_we_lsu) begin
            rf_wdata_wb_o = rf_wdata_lsu_i;
        end
        if (FpEnable && head_valid) begin
            if (head_is_other && head.fp_wen) begin
                fp_rf_wen_wb_o   = 1'b1;
                fp_rf_wdata_wb_o = head.fp_wdata[FPU_WIDTH-1:0];
            end else if (head_is_load && rf_we_lsu_i && head.fp_load) begin
                fp_rf_wen_wb_o   = 1'b1;
                fp_rf_wdata_wb_o = fp_lsu_boxed[FPU_WIDTH-1:0];
            end
        end
    end

    assign pc_wb_o         = head_valid ? head.pc : '0;
    assign rf_waddr_wb_o   = head_valid ? head.waddr : '0;
    assign instr_done_wb_o = head_done;

    // A store/load that returns a bus error still retires but is not
    // counted as a successfully retired instruction.
    assign perf_instr_ret_wb_o = head_done & head.perf_count &
                                 ~(lsu_resp_valid_i & lsu_resp_err_i);
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head.compressed;

    a_resp_needs_mem_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_i |-> (head_valid && !head_is_other));

    a_int_fp_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rf_we_wb_o && fp_rf_wen_wb_o));

    a_single_int_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({int_we_alu, int_we_lsu}));

    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= DepthCnt);

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// tb_ibex_wb_buffer
// Directed bench for ibex_wb_buffer with Depth=2, FpEnable=1, FPU_WIDTH=64.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_ibex_wb_buffer;
    import ibex_pkg::*;

    localparam int FpW = 64;

    logic                 clk;
    logic                 rst_n;
    logic                 en_wb;
    wb_instr_type_e       instr_type;
    logic [31:0]          pc_id;
    logic                 compressed_id;
    logic                 perf_count_id;
    logic [4:0]           waddr_id;
    logic [31:0]          wdata_id;
    logic                 we_id;
    logic                 fp_wen_id;
    logic [FpW-1:0]       fp_wdata_id;
    logic                 fp_load;
    logic                 resp_valid;
    logic                 resp_err;
    logic                 we_lsu;
    logic [31:0]          wdata_lsu;
    logic [1:0][4:0]      raddr;

    logic                 ready;
    logic                 out_load;
    logic                 out_store;
    logic [31:0]          pc_wb;
    logic                 instr_done;
    logic                 perf_ret;
    logic                 perf_ret_c;
    logic [4:0]           waddr_wb;
    logic                 we_wb;
    logic [31:0]          wdata_wb;
    logic                 fp_wen_wb;
    logic [FpW-1:0]       fp_wdata_wb;
    logic [1:0]           fwd_valid;
    logic [1:0][31:0]     fwd_data;
    logic [1:0]           hazard;
    logic [31:0]          fp_pending;

    int compared   = 0;
    int mismatched = 0;

    ibex_wb_buffer #(
        .Depth     (2),
        .FpEnable  (1'b1),
        .FPU_WIDTH (FpW)
    ) dut (
        .clk_i                          (clk),
        .rst_ni                         (rst_n),
        .en_wb_i                        (en_wb),
        .instr_type_wb_i                (instr_type),
        .pc_id_i                        (pc_id),
        .instr_is_compressed_id_i       (compressed_id),
        .instr_perf_count_id_i          (perf_count_id),
        .rf_waddr_id_i                  (waddr_id),
        .rf_wdata_id_i                  (wdata_id),
        .rf_we_id_i                     (we_id),
        .fp_rf_wen_id_i                 (fp_wen_id),
        .fp_rf_wdata_id_i               (fp_wdata_id),
        .fp_load_i                      (fp_load),
        .lsu_resp_valid_i               (resp_valid),
        .lsu_resp_err_i                 (resp_err),
        .rf_we_lsu_i                    (we_lsu),
        .rf_wdata_lsu_i                 (wdata_lsu),
        .rf_raddr_i                     (raddr),
        .ready_wb_o                     (ready),
        .outstanding_load_wb_o          (out_load),
        .outstanding_store_wb_o         (out_store),
        .pc_wb_o                        (pc_wb),
        .instr_done_wb_o                (instr_done),
        .perf_instr_ret_wb_o            (perf_ret),
        .perf_instr_ret_compressed_wb_o (perf_ret_c),
        .rf_waddr_wb_o                  (waddr_wb),
        .rf_we_wb_o                     (we_wb),
        .rf_wdata_wb_o                  (wdata_wb),
        .fp_rf_wen_wb_o                 (fp_wen_wb),
        .fp_rf_wdata_wb_o               (fp_wdata_wb),
        .rf_fwd_valid_o                 (fwd_valid),
        .rf_fwd_data_o                  (fwd_data),
        .rf_hazard_o                    (hazard),
        .fp_rf_pending_o                (fp_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the directed sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearInputs();
        en_wb         = 1'b0;
        instr_type    = WB_INSTR_OTHER;
        pc_id         = '0;
        compressed_id = 1'b0;
        perf_count_id = 1'b0;
        waddr_id      = '0;
        wdata_id      = '0;
        we_id         = 1'b0;
        fp_wen_id     = 1'b0;
        fp_wdata_id   = '0;
        fp_load       = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        we_lsu        = 1'b0;
        wdata_lsu     = '0;
        raddr         = '0;
    endtask

    // Start of a directed step: wait for the falling edge and idle inputs.
    task automatic applyStimulus();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic offerAlu(input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] data, input logic comp);
        en_wb         = 1'b1;
        instr_type    = WB_INSTR_OTHER;
        pc_id         = pc;
        waddr_id      = rd;
        wdata_id      = data;
        we_id         = 1'b1;
        perf_count_id = 1'b1;
        compressed_id = comp;
    endtask

    task automatic offerFpAlu(input logic [31:0] pc, input logic [4:0] rd,
                              input logic [FpW-1:0] data);
        en_wb         = 1'b1;
        instr_type    = WB_INSTR_OTHER;
        pc_id         = pc;
        waddr_id      = rd;
        fp_wen_id     = 1'b1;
        fp_wdata_id   = data;
        perf_count_id = 1'b1;
    endtask

    task automatic offerLoad(input logic [31:0] pc, input logic [4:0] rd, input logic fp);
        en_wb         = 1'b1;
        instr_type    = WB_INSTR_LOAD;
        pc_id         = pc;
        waddr_id      = rd;
        fp_load       = fp;
        perf_count_id = 1'b1;
    endtask

    task automatic offerStore(input logic [31:0] pc);
        en_wb         = 1'b1;
        instr_type    = WB_INSTR_STORE;
        pc_id         = pc;
        perf_count_id = 1'b1;
    endtask

    task automatic giveResp(input logic [31:0] data, input logic err, input logic we);
        resp_valid = 1'b1;
        resp_err   = err;
        we_lsu     = we;
        wdata_lsu  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_done", instr_done, 0);
        checkOutput("rst_pc", pc_wb, 0);
        checkOutput("rst_waddr", waddr_wb, 0);
        checkOutput("rst_we", we_wb, 0);
        checkOutput("rst_fp_wen", fp_wen_wb, 0);
        checkOutput("rst_out_load", out_load, 0);
        checkOutput("rst_out_store", out_store, 0);
        checkOutput("rst_fp_pending", fp_pending, 0);
        checkOutput("rst_fwd_valid", fwd_valid, 0);
        checkOutput("rst_hazard", hazard, 0);
        checkOutput("rst_perf", perf_ret, 0);
        applyStimulus();
        rst_n = 1'b1;

        $display("[TB] ALU forwarding and in-order retire");
        applyStimulus();
        offerAlu(32'h100, 5'd5, 32'h11, 1'b0);
        raddr[0] = 5'd5;
        #1;
        checkOutput("alu1_ready", ready, 1);
        checkOutput("alu1_fwd_invisible", fwd_valid, 2'b00);

        applyStimulus();
        offerAlu(32'h104, 5'd5, 32'h22, 1'b1);
        raddr[0] = 5'd5;
        #1;
        checkOutput("alu1_done", instr_done, 1);
        checkOutput("alu1_pc", pc_wb, 32'h100);
        checkOutput("alu1_we", we_wb, 1);
        checkOutput("alu1_waddr", waddr_wb, 5);
        checkOutput("alu1_wdata", wdata_wb, 32'h11);
        checkOutput("alu1_fwd_valid", fwd_valid, 2'b01);
        checkOutput("alu1_fwd_data", fwd_data[0], 32'h11);
        checkOutput("alu1_perf", perf_ret, 1);
        checkOutput("alu1_perf_c", perf_ret_c, 0);

        applyStimulus();
        raddr[0] = 5'd5;
        #1;
        checkOutput("alu2_pc", pc_wb, 32'h104);
        checkOutput("alu2_wdata", wdata_wb, 32'h22);
        checkOutput("alu2_fwd_data", fwd_data[0], 32'h22);
        checkOutput("alu2_perf_c", perf_ret_c, 1);

        $display("[TB] load-use hazard");
        applyStimulus();
        offerLoad(32'h200, 5'd7, 1'b0);
        #1;
        checkOutput("ld7_out_load_before", out_load, 0);
        checkOutput("ld7_done_empty", instr_done, 0);

        applyStimulus();
        offerAlu(32'h204, 5'd8, 32'h88, 1'b0);
        raddr[0] = 5'd7;
        raddr[1] = 5'd8;
        #1;
        checkOutput("ld7_hazard", hazard, 2'b01);
        checkOutput("ld7_fwd_valid", fwd_valid, 2'b00);
        checkOutput("ld7_out_load", out_load, 1);
        checkOutput("ld7_wait", instr_done, 0);
        checkOutput("ld7_ready", ready, 1);
        checkOutput("ld7_pc", pc_wb, 32'h200);

        applyStimulus();
        giveResp(32'hDEAD, 1'b0, 1'b1);
        raddr[0] = 5'd7;
        raddr[1] = 5'd8;
        #1;
        checkOutput("ld7_full_ready", ready, 1);
        checkOutput("ld7_resp_hazard", hazard, 2'b01);
        checkOutput("ld7_resp_fwd_valid", fwd_valid, 2'b10);
        checkOutput("ld7_resp_fwd_b", fwd_data[1], 32'h88);
        checkOutput("ld7_we", we_wb, 1);
        checkOutput("ld7_waddr", waddr_wb, 7);
        checkOutput("ld7_wdata", wdata_wb, 32'hDEAD);
        checkOutput("ld7_done", instr_done, 1);

        applyStimulus();
        offerAlu(32'h208, 5'd0, 32'h55, 1'b0);
        #1;
        checkOutput("alu8_pc", pc_wb, 32'h204);
        checkOutput("alu8_waddr", waddr_wb, 8);
        checkOutput("alu8_wdata", wdata_wb, 32'h88);
        checkOutput("alu8_out_load", out_load, 0);

        applyStimulus();
        #1;
        checkOutput("x0_fwd_valid", fwd_valid, 2'b00);
        checkOutput("x0_pc", pc_wb, 32'h208);

        $display("[TB] full buffer backpressure");
        applyStimulus();
        offerLoad(32'h300, 5'd10, 1'b0);
        #1;
        applyStimulus();
        offerLoad(32'h304, 5'd11, 1'b0);
        #1;
        checkOutput("fill_ready", ready, 1);

        applyStimulus();
        offerAlu(32'h308, 5'd12, 32'hCC, 1'b0);
        #1;
        checkOutput("full_ready", ready, 0);
        checkOutput("full_done", instr_done, 0);

        applyStimulus();
        offerAlu(32'h308, 5'd12, 32'hCC, 1'b0);
        giveResp(32'h1010, 1'b0, 1'b1);
        #1;
        checkOutput("full_pushpop_ready", ready, 1);
        checkOutput("full_ld10_waddr", waddr_wb, 10);
        checkOutput("full_ld10_wdata", wdata_wb, 32'h1010);

        applyStimulus();
        #1;
        checkOutput("still_full_ready", ready, 0);
        checkOutput("still_full_pc", pc_wb, 32'h304);

        applyStimulus();
        giveResp(32'h1111, 1'b0, 1'b1);
        #1;
        checkOutput("ld11_waddr", waddr_wb, 11);
        checkOutput("ld11_wdata", wdata_wb, 32'h1111);

        applyStimulus();
        #1;
        checkOutput("alu12_pc", pc_wb, 32'h308);
        checkOutput("alu12_wdata", wdata_wb, 32'hCC);
        checkOutput("alu12_out_load", out_load, 0);

        $display("[TB] FP writes");
        applyStimulus();
        offerLoad(32'h400, 5'd3, 1'b1);
        #1;
        applyStimulus();
        giveResp(32'h3F80_0000, 1'b0, 1'b1);
        #1;
        checkOutput("fld_pending", fp_pending, 32'h0000_0008);
        checkOutput("fld_fp_wen", fp_wen_wb, 1);
        checkOutput("fld_fp_wdata", fp_wdata_wb, 64'hFFFF_FFFF_3F80_0000);
        checkOutput("fld_int_we", we_wb, 0);

        applyStimulus();
        offerFpAlu(32'h404, 5'd4, 64'h1234_5678_9ABC_DEF0);
        #1;
        checkOutput("fld_pending_clear", fp_pending, 0);

        applyStimulus();
        #1;
        checkOutput("falu_pending", fp_pending, 32'h0000_0010);
        checkOutput("falu_fp_wen", fp_wen_wb, 1);
        checkOutput("falu_fp_wdata", fp_wdata_wb, 64'h1234_5678_9ABC_DEF0);
        checkOutput("falu_waddr", waddr_wb, 4);

        $display("[TB] store with bus error");
        applyStimulus();
        offerStore(32'h500);
        #1;
        applyStimulus();
        giveResp(32'h0, 1'b1, 1'b0);
        #1;
        checkOutput("st_out_store", out_store, 1);
        checkOutput("st_done", instr_done, 1);
        checkOutput("st_perf", perf_ret, 0);
        checkOutput("st_we", we_wb, 0);
        checkOutput("st_fp_wen", fp_wen_wb, 0);
        checkOutput("st_pc", pc_wb, 32'h500);

        $display("[TB] reset with loads pending");
        applyStimulus();
        offerLoad(32'h600, 5'd20, 1'b0);
        #1;
        applyStimulus();
        offerLoad(32'h604, 5'd21, 1'b0);
        #1;
        applyStimulus();
        #1;
        checkOutput("pend_ready", ready, 0);
        checkOutput("pend_out_load", out_load, 1);

        applyStimulus();
        rst_n = 1'b0;
        giveResp(32'hBAD, 1'b0, 1'b1);
        #1;
        checkOutput("midrst_ready", ready, 1);
        checkOutput("midrst_out_load", out_load, 0);
        checkOutput("midrst_we", we_wb, 0);
        checkOutput("midrst_done", instr_done, 0);
        checkOutput("midrst_pc", pc_wb, 0);

        applyStimulus();
        rst_n = 1'b1;
        offerAlu(32'h700, 5'd6, 32'h66, 1'b0);
        #1;
        checkOutput("post_rst_ready", ready, 1);
        checkOutput("post_rst_out_load", out_load, 0);

        applyStimulus();
        #1;
        checkOutput("post_rst_pc", pc_wb, 32'h700);
        checkOutput("post_rst_wdata", wdata_wb, 32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
